// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with memory handshake, fetch timeout, halt request and retired-instruction count.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_input,
  input  logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        halt_req,
  output logic [1:0]  stage,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] retired,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] to_cnt;
  logic        in_fetch;
  logic        to_hit;

  assign in_fetch = (state == ST_FETCH);

  // An ack in the cycle the limit is reached takes priority over the timeout.
  assign to_hit = in_fetch && !imem_ack && (FETCH_TIMEOUT != 0) &&
                  ((to_cnt + 32'd1) == FETCH_TIMEOUT);

  // The request is gated by rst_n so it drops the instant reset asserts.
  assign imem_req  = in_fetch && rst_n;
  assign imem_addr = pc;
  assign stage     = (state == ST_HALT) ? 2'd3 : state[1:0];
  assign halted    = (state == ST_HALT);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (imem_ack)    state_nxt = ST_DECODE;
        else if (to_hit) state_nxt = ST_HALT;
      end
      ST_DECODE:    state_nxt = ST_EXECUTE;
      ST_EXECUTE:   if (!stall) state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = halt_req ? ST_HALT : ST_FETCH;
      default:      state_nxt = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      retired     <= 32'd0;
      fetch_err   <= 1'b0;
      to_cnt      <= 32'd0;
    end else begin
      state <= state_nxt;

      if (in_fetch && !imem_ack) to_cnt <= to_cnt + 32'd1;
      else                       to_cnt <= 32'd0;

      if (in_fetch) begin
        if (imem_ack) begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          if (pc_en) pc <= pc_input;
        end else if (to_hit) begin
          fetch_err <= 1'b1;
        end
      end

      if (state == ST_WRITEBACK) begin
        retired     <= retired + 32'd1;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle table through a scoreboard queue,
// then hand-written sequences for reset, timeout, halt and counter wrap.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_input;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        halt_req;
  logic [1:0]  stage;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] retired;
  logic        halted;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_input(pc_input), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .halt_req(halt_req),
    .stage(stage), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .retired(retired), .halted(halted), .fetch_err(fetch_err)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        stall;
    logic        halt;
    logic [1:0]  e_stage;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_ret;
    logic        e_halted;
  } vec_t;

  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are compared at the falling edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    imem_ack   = v.ack;
    imem_rdata = v.rdata;
    pc_input   = v.pc_in;
    pc_en      = v.pc_en;
    stall      = v.stall;
    halt_req   = v.halt;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("v%0d stage", idx), 32'(stage), 32'(e.e_stage));
    check($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(e.e_req));
    if (e.e_req) check($sformatf("v%0d imem_addr", idx), imem_addr, e.e_pc);
    check($sformatf("v%0d pc", idx), pc, e.e_pc);
    check($sformatf("v%0d instr", idx), instr, e.e_instr);
    check($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 32'(e.e_valid));
    check($sformatf("v%0d retired", idx), retired, e.e_ret);
    check($sformatf("v%0d halted", idx), 32'(halted), 32'(e.e_halted));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0; imem_rdata = 32'd0; pc_input = 32'd0;
    pc_en = 1'b0; stall = 1'b0; halt_req = 1'b0;
  endtask

  // Asserts reset away from any clock edge, checks the async values, then releases.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #2;
    check({tag, " rst imem_req"}, 32'(imem_req), 32'd0);
    check({tag, " rst stage"}, 32'(stage), 32'd0);
    check({tag, " rst pc"}, pc, 32'd0);
    check({tag, " rst instr"}, instr, 32'd0);
    check({tag, " rst instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " rst retired"}, retired, 32'd0);
    check({tag, " rst halted"}, 32'(halted), 32'd0);
    check({tag, " rst fetch_err"}, 32'(fetch_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check({tag, " post-rst imem_req"}, 32'(imem_req), 32'd1);
    check({tag, " post-rst imem_addr"}, imem_addr, 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] IA = 32'hA000_0001;
  localparam logic [31:0] IB = 32'hA000_0002;
  localparam logic [31:0] IC = 32'hA000_0003;
  localparam logic [31:0] ID = 32'hA000_0004;

  initial begin
    vec_t vt[26];
    logic [31:0] exp_ret;

    //           ack rdata  pc_in       en  stl hlt  stg req pc          instr val ret halted
    vt[0]  = '{1'b1, IA,    32'h4,     1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0,   32'h0, 1'b0, 32'd0, 1'b0};
    vt[1]  = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h4,   IA,    1'b1, 32'd0, 1'b0};
    vt[2]  = '{1'b1, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h4,   IA,    1'b1, 32'd0, 1'b0};
    vt[3]  = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h4,   IA,    1'b1, 32'd0, 1'b0};
    vt[4]  = '{1'b1, IB,    32'h8,     1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h4,   IA,    1'b0, 32'd1, 1'b0};
    vt[5]  = '{1'b0, 32'h0, 32'h0,     1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 32'h8,   IB,    1'b1, 32'd1, 1'b0};
    vt[6]  = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h8,   IB,    1'b1, 32'd1, 1'b0};
    vt[7]  = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h8,   IB,    1'b1, 32'd1, 1'b0};
    vt[8]  = '{1'b0, 32'h0, 32'h100,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h8,   IB,    1'b0, 32'd2, 1'b0};
    vt[9]  = '{1'b0, 32'h0, 32'h100,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h8,   IB,    1'b0, 32'd2, 1'b0};
    vt[10] = '{1'b0, 32'h0, 32'h100,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h8,   IB,    1'b0, 32'd2, 1'b0};
    vt[11] = '{1'b1, IC,    32'h100,   1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h8,   IB,    1'b0, 32'd2, 1'b0};
    vt[12] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[13] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[14] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[15] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[16] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[17] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[18] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[19] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h100, IC,    1'b1, 32'd2, 1'b0};
    vt[20] = '{1'b1, ID,    32'h104,   1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h100, IC,    1'b0, 32'd3, 1'b0};
    vt[21] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h100, ID,    1'b1, 32'd3, 1'b0};
    vt[22] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h100, ID,    1'b1, 32'd3, 1'b0};
    vt[23] = '{1'b0, 32'h0, 32'h0,     1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h100, ID,    1'b1, 32'd3, 1'b0};
    vt[24] = '{1'b1, 32'h5, 32'h200,   1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 32'h100, ID,    1'b0, 32'd4, 1'b1};
    vt[25] = '{1'b1, 32'h6, 32'h300,   1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h100, ID,    1'b0, 32'd4, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    tick(2);
    check("init imem_req", 32'(imem_req), 32'd0);
    check("init stage", 32'(stage), 32'd0);
    check("init pc", pc, 32'd0);
    check("init retired", retired, 32'd0);
    check("init fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) apply(vt[i], i);
    check("halt fetch_err", 32'(fetch_err), 32'd0);

    // Reset out of HALT restores everything and refetches from the reset PC.
    idle_inputs();
    do_reset("halt");

    // Reset in the middle of a pending fetch aborts it.
    tick(3);
    check("midfetch req before rst", 32'(imem_req), 32'd1);
    do_reset("midfetch");

    // No ack at all: fetch gives up after 16 FETCH cycles.
    tick(15);
    check("to15 stage", 32'(stage), 32'd0);
    check("to15 halted", 32'(halted), 32'd0);
    check("to15 imem_req", 32'(imem_req), 32'd1);
    tick(1);
    check("to16 halted", 32'(halted), 32'd1);
    check("to16 fetch_err", 32'(fetch_err), 32'd1);
    check("to16 imem_req", 32'(imem_req), 32'd0);
    check("to16 stage", 32'(stage), 32'd3);
    check("to16 pc", pc, 32'd0);
    check("to16 instr", instr, 32'd0);
    tick(3);
    check("to16 still halted", 32'(halted), 32'd1);
    check("to16 err sticky", 32'(fetch_err), 32'd1);

    // Ack in the 16th cycle beats the timeout.
    do_reset("ack16");
    tick(15);
    imem_ack = 1'b1; imem_rdata = 32'hBEEF_0016; pc_input = 32'h40; pc_en = 1'b1;
    tick(1);
    idle_inputs();
    check("ack16 stage", 32'(stage), 32'd1);
    check("ack16 fetch_err", 32'(fetch_err), 32'd0);
    check("ack16 halted", 32'(halted), 32'd0);
    check("ack16 instr", instr, 32'hBEEF_0016);
    check("ack16 pc", pc, 32'h40);

    // Retired counter wrap, starting one short of 2^32.
    tick(3);
    check("wrap pre stage", 32'(stage), 32'd0);
    check("wrap pre retired", retired, 32'd1);
    force dut.retired = 32'hFFFF_FFFF;
    #1 release dut.retired;
    exp_ret = 32'hFFFF_FFFF;
    check("wrap forced", retired, exp_ret);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick(1);
    idle_inputs();
    tick(3);
    exp_ret = exp_ret + 32'd1;
    check("wrap stage", 32'(stage), 32'd0);
    check("wrap retired", retired, exp_ret);
    check("wrap imem_addr", imem_addr, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
- REQ-002: Parameter FETCH_TIMEOUT, default 16, max cycles a fetch may wait for imem_ack; 0 disables the timeout.
- REQ-003: Port clk  in  1  sole clock; all state updates on rising edge.
- REQ-004: Port rst_n  in  1  reset, asynchronous assert, active-low.
- REQ-005: Port pc_input  in  32  next-PC value from the PC control stage.
- REQ-006: Port pc_en  in  1  PC load enable from the PC control stage.
- REQ-007: Port imem_req  out  1  instruction memory request.
- REQ-008: Port imem_addr  out  32  instruction fetch address.
- REQ-009: Port imem_ack  in  1  memory completion; imem_rdata valid in the same cycle.
- REQ-010: Port imem_rdata  in  32  fetched instruction word.
- REQ-011: Port stall  in  1  extends EXECUTE while high.
- REQ-012: Port halt_req  in  1  request to stop after the current instruction.
- REQ-013: Port stage  out  2  current stage: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3 (codebase STAGE_* encodings).
- REQ-014: Port pc  out  32  current program counter.
- REQ-015: Port instr  out  32  latched instruction word.
- REQ-016: Port instr_valid  out  1  instr holds a live instruction.
- REQ-017: Port retired  out  32  count of completed instructions.
- REQ-018: Port halted  out  1  sequencer stopped.
- REQ-019: Port fetch_err  out  1  sticky fetch-timeout flag.

Function
- REQ-020: FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT; stage output reports WRITEBACK encoding while in HALT.
- REQ-021: FETCH: imem_req=1 and imem_addr=pc every cycle in FETCH; imem_req=0 in all other states.
- REQ-022: Fetch completes in any FETCH cycle with imem_ack=1 (zero-wait ack in the first FETCH cycle allowed); imem_ack outside FETCH ignored.
- REQ-023: On fetch completion: instr<=imem_rdata, instr_valid<=1, next state DECODE.
- REQ-024: PC loads pc_input only in the fetch-completion cycle and only if pc_en=1; otherwise pc holds; imem_addr therefore stable for the whole request.
- REQ-025: DECODE lasts exactly 1 cycle, then EXECUTE.
- REQ-026: EXECUTE: stall=1 holds EXECUTE; stall=0 moves to WRITEBACK next edge; minimum 1 cycle.
- REQ-027: WRITEBACK lasts 1 cycle; retired increments by 1 (wraps 32'hFFFF_FFFF->0); instr_valid<=0; next state HALT if halt_req=1 that cycle, else FETCH.
- REQ-028: halt_req sampled only in WRITEBACK; ignored in all other states.
- REQ-029: Timeout counter clears on FETCH entry, increments each FETCH cycle without ack; when FETCH_TIMEOUT!=0 and counter reaches FETCH_TIMEOUT without ack: fetch_err<=1, next state HALT, pc and instr unchanged.
- REQ-030: Ack arriving in the same cycle the counter reaches FETCH_TIMEOUT wins: normal completion, no error.
- REQ-031: HALT: halted=1, imem_req=0, no state changes; exit only via reset.
- REQ-032: Nominal instruction latency with zero-wait memory and no stall: 4 cycles FETCH->FETCH.

Reset
- REQ-033: rst_n=0 asynchronously forces: state FETCH, stage=0, pc=RESET_PC, instr=0, instr_valid=0, retired=0, halted=0, fetch_err=0, timeout counter=0, imem_req=0 while rst_n=0.
- REQ-034: Reset mid-fetch aborts the transaction; first FETCH after release re-issues request at RESET_PC.
- REQ-035: After rst_n rises, imem_req=1 with imem_addr=RESET_PC in the first cycle.

Verification
- REQ-036: Zero-wait ack, pc_en=1, pc_input=pc+4, stall=0 -> stage 0,1,2,3 repeating, pc 0->4->8, retired +1 per 4 cycles.
- REQ-037: imem_ack delayed 3 cycles, pc_input=32'h100 -> imem_addr held at 0 for 4 cycles, pc=32'h100 after ack, instr=imem_rdata.
- REQ-038: stall=1 for 5 cycles in EXECUTE -> EXECUTE lasts 6 cycles, retired increments once.
- REQ-039: FETCH_TIMEOUT=16, no ack -> fetch_err=1, halted=1 after 16 FETCH cycles, imem_req=0; ack on 16th cycle -> no error, DECODE.
- REQ-040: halt_req=1 in DECODE only -> ignored; halt_req=1 in WRITEBACK -> halted=1, retired counted; then rst_n pulse -> all outputs at reset values, fetch at RESET_PC.
- REQ-041: retired preset near wrap via 2^32 instructions or forced start at 32'hFFFF_FFFF -> one WRITEBACK yields retired=0.
